// File: rtl/fx_div_sqrt.sv
// fx_div_sqrt: shared iterative Q24.8 signed divider / square-root unit.
// One operation in flight; start/done handshake. Divide retires one quotient
// bit per cycle over a (WIDTH+FRAC_BITS)-bit scaled dividend, square root
// retires one root bit per cycle over the same scaled radicand.
module fx_div_sqrt #(
    parameter int FRAC_BITS = 8,
    parameter int WIDTH     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] val,
    output logic             err
);

    // Scaled operand width, root width and partial-remainder widths.
    localparam int EXT    = WIDTH + FRAC_BITS;
    localparam int ROOT_W = EXT / 2;
    localparam int ACC_W  = WIDTH + 2;
    localparam int REM_W  = ACC_W + 2;
    localparam int CNT_W  = $clog2(EXT + 1);

    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [EXT-1:0]   MAX_MAG = {{FRAC_BITS{1'b0}}, MAX_POS};
    localparam logic [EXT-1:0]   MIN_MAG = {{FRAC_BITS{1'b0}}, MIN_NEG};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Unsigned magnitude of a two's-complement word; the most-negative
    // value maps to 2^(WIDTH-1), which still fits the unsigned result.
    function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] x);
        abs_mag = x[WIDTH-1] ? (~x + ONE) : x;
    endfunction

    state_t             state_r, state_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               op_r;
    logic               neg_r;      // divide: result negative; sqrt: radicand negative
    logic               sign_a_r;
    logic               zero_r;     // divisor was zero
    logic [WIDTH-1:0]   dmag_r;
    logic [EXT-1:0]     sh_r;       // dividend/radicand, consumed from the top
    logic [EXT-1:0]     quo_r;      // quotient or root, built from the bottom
    logic [ACC_W-1:0]   acc_r;      // partial remainder

    logic               accept_s, iter_s, finish_s;
    logic [REM_W-1:0]   rem_s, sub_s;
    logic               ge_s;
    logic [WIDTH-1:0]   res_s;
    logic               res_err_s;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic and datapath strobes; FINISH doubles as an accept
    // state so a new request can be taken on the done cycle.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        iter_s       = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            IDLE, FINISH: begin
                if (start) begin
                    accept_s     = 1'b1;
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    finish_s     = 1'b1;
                    state_next_s = FINISH;
                end else begin
                    iter_s       = 1'b1;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // One restoring step: shift in the next dividend bit (or radicand bit
    // pair) and subtract the divisor (or trial value 4*root+1) if it fits.
    always_comb begin
        rem_s = {REM_W{1'b0}};
        sub_s = {REM_W{1'b0}};
        if (op_r) begin
            rem_s = {acc_r, sh_r[EXT-1:EXT-2]};
            sub_s = {{(REM_W-ROOT_W-2){1'b0}}, quo_r[ROOT_W-1:0], 2'b01};
        end else begin
            rem_s = {1'b0, acc_r, sh_r[EXT-1]};
            sub_s = {{(REM_W-WIDTH){1'b0}}, dmag_r};
        end
        ge_s = (rem_s >= sub_s);
    end

    // Final sign application, saturation and error classification.
    always_comb begin
        res_s     = {WIDTH{1'b0}};
        res_err_s = 1'b0;
        if (op_r) begin
            if (neg_r) begin
                res_s     = {WIDTH{1'b0}};
                res_err_s = 1'b1;
            end else begin
                res_s     = {{(WIDTH-ROOT_W){1'b0}}, quo_r[ROOT_W-1:0]};
                res_err_s = 1'b0;
            end
        end else if (zero_r) begin
            res_s     = sign_a_r ? MIN_NEG : MAX_POS;
            res_err_s = 1'b1;
        end else if (!neg_r && (quo_r > MAX_MAG)) begin
            res_s     = MAX_POS;
            res_err_s = 1'b1;
        end else if (neg_r && (quo_r > MIN_MAG)) begin
            res_s     = MIN_NEG;
            res_err_s = 1'b1;
        end else if (neg_r) begin
            res_s     = ~quo_r[WIDTH-1:0] + ONE;
            res_err_s = 1'b0;
        end else begin
            res_s     = quo_r[WIDTH-1:0];
            res_err_s = 1'b0;
        end
    end

    // Operand capture and iteration datapath.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r    <= {CNT_W{1'b0}};
            op_r     <= 1'b0;
            neg_r    <= 1'b0;
            sign_a_r <= 1'b0;
            zero_r   <= 1'b0;
            dmag_r   <= {WIDTH{1'b0}};
            sh_r     <= {EXT{1'b0}};
            quo_r    <= {EXT{1'b0}};
            acc_r    <= {ACC_W{1'b0}};
        end else if (accept_s) begin
            cnt_r    <= op ? CNT_W'(ROOT_W) : CNT_W'(EXT);
            op_r     <= op;
            neg_r    <= op ? a[WIDTH-1] : (a[WIDTH-1] ^ b[WIDTH-1]);
            sign_a_r <= a[WIDTH-1];
            zero_r   <= (b == {WIDTH{1'b0}});
            dmag_r   <= abs_mag(b);
            sh_r     <= op ? {a, {FRAC_BITS{1'b0}}} : {abs_mag(a), {FRAC_BITS{1'b0}}};
            quo_r    <= {EXT{1'b0}};
            acc_r    <= {ACC_W{1'b0}};
        end else if (iter_s) begin
            cnt_r    <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            sh_r     <= op_r ? {sh_r[EXT-3:0], 2'b00} : {sh_r[EXT-2:0], 1'b0};
            quo_r    <= {quo_r[EXT-2:0], ge_s};
            acc_r    <= ACC_W'(ge_s ? (rem_s - sub_s) : rem_s);
        end else begin
            cnt_r    <= cnt_r;
        end
    end

    // Registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            val  <= {WIDTH{1'b0}};
            err  <= 1'b0;
        end else if (accept_s) begin
            busy <= 1'b1;
            done <= 1'b0;
        end else if (finish_s) begin
            busy <= 1'b0;
            done <= 1'b1;
            val  <= res_s;
            err  <= res_err_s;
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fx_div_sqrt.sv
// Self-checking bench for fx_div_sqrt: directed vector table, handshake and
// reset sequences, then random operations against an arithmetic model.
module tb_fx_div_sqrt;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy, done, err;
    logic [31:0] val;

    int n_cmp = 0;
    int n_bad = 0;

    fx_div_sqrt #(.FRAC_BITS(8), .WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .val(val), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] v;
        logic        e;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: Q24.8 arithmetic on 64-bit signed integers.
    function automatic void model(input logic o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] v, output logic e);
        longint sa, sb, q, n, r;
        sa = longint'($signed(x));
        sb = longint'($signed(y));
        v = 32'd0;
        e = 1'b0;
        if (!o) begin
            if (sb == 64'sd0) begin
                v = (sa >= 64'sd0) ? 32'h7FFFFFFF : 32'h80000000;
                e = 1'b1;
            end else begin
                q = (sa * 64'sd256) / sb;
                if (q > 64'sd2147483647) begin
                    v = 32'h7FFFFFFF; e = 1'b1;
                end else if (q < -64'sd2147483648) begin
                    v = 32'h80000000; e = 1'b1;
                end else begin
                    v = q[31:0]; e = 1'b0;
                end
            end
        end else begin
            if (sa < 64'sd0) begin
                v = 32'd0; e = 1'b1;
            end else begin
                n = sa * 64'sd256;
                r = longint'($sqrt(real'(n)));
                while (r * r > n) r--;
                while ((r + 64'sd1) * (r + 64'sd1) <= n) r++;
                v = r[31:0]; e = 1'b0;
            end
        end
    endfunction

    // Called at a falling edge: present a request for one rising edge.
    task automatic launch(input logic o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts rising edges from the accepting edge until done is seen.
    task automatic wait_done(output int lat, output logic busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        while (!done && lat < 100) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_check(input string nm, input logic o, input logic [31:0] x,
                             input logic [31:0] y, input logic [31:0] ev, input logic ee);
        int   lat;
        logic bok;
        launch(o, x, y);
        wait_done(lat, bok);
        chk({nm, "_latency"}, 32'(lat), o ? 32'd21 : 32'd41);
        chk({nm, "_busy_during"}, {31'd0, bok}, 32'd1);
        chk({nm, "_val"}, val, ev);
        chk({nm, "_err"}, {31'd0, err}, {31'd0, ee});
        chk({nm, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk({nm, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int          lat, pulses, first;
        logic        bok, o, ee;
        logic [31:0] x, y, ev, held;

        tbl[0]  = '{1'b0, 32'h00000300, 32'h00000200, 32'h00000180, 1'b0};
        tbl[1]  = '{1'b0, 32'hFFFFFD00, 32'h00000200, 32'hFFFFFE80, 1'b0};
        tbl[2]  = '{1'b0, 32'h00000100, 32'h00000300, 32'h00000055, 1'b0};
        tbl[3]  = '{1'b1, 32'h00000400, 32'h00000000, 32'h00000200, 1'b0};
        tbl[4]  = '{1'b1, 32'h00000200, 32'h00000000, 32'h0000016A, 1'b0};
        tbl[5]  = '{1'b1, 32'h7FFFFFFF, 32'h00000000, 32'h000B504F, 1'b0};
        tbl[6]  = '{1'b0, 32'h00000100, 32'h00000000, 32'h7FFFFFFF, 1'b1};
        tbl[7]  = '{1'b0, 32'hFFFFFF00, 32'h00000000, 32'h80000000, 1'b1};
        tbl[8]  = '{1'b0, 32'h7FFFFF00, 32'h00000001, 32'h7FFFFFFF, 1'b1};
        tbl[9]  = '{1'b1, 32'hFFFFFF00, 32'h00000000, 32'h00000000, 1'b1};
        tbl[10] = '{1'b0, 32'h80000000, 32'h00000100, 32'h80000000, 1'b0};
        tbl[11] = '{1'b0, 32'h80000000, 32'hFFFFFF00, 32'h7FFFFFFF, 1'b1};
        tbl[12] = '{1'b0, 32'h00000000, 32'h00000500, 32'h00000000, 1'b0};
        tbl[13] = '{1'b0, 32'h00000000, 32'h00000000, 32'h7FFFFFFF, 1'b1};
        tbl[14] = '{1'b1, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0};
        tbl[15] = '{1'b0, 32'hFFFFFF00, 32'hFFFFFE00, 32'h00000080, 1'b0};
        tbl[16] = '{1'b0, 32'h00000001, 32'h7FFFFFFF, 32'h00000000, 1'b0};
        tbl[17] = '{1'b0, 32'hFFFFFFFF, 32'h00000300, 32'h00000000, 1'b0};

        // Reset state.
        #12;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_val", val, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Directed vectors.
        for (int i = 0; i < 18; i++) begin
            run_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].v, tbl[i].e);
        end

        // Second start five cycles into a divide is ignored.
        launch(1'b0, 32'h00000300, 32'h00000200);
        pulses = 0;
        first = -1;
        held = 32'd0;
        for (int i = 0; i < 60; i++) begin
            if (i == 4) begin
                start = 1'b1; a = 32'h00000100; b = 32'h00000300;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                pulses++;
                if (first < 0) begin
                    first = i;
                    held = val;
                end
            end
            @(negedge clk);
        end
        chk("ignore_pulses", 32'(pulses), 32'd1);
        chk("ignore_latency", 32'(first), 32'd41);
        chk("ignore_val", held, 32'h00000180);

        // Back-to-back: new start presented on the done cycle.
        launch(1'b0, 32'h00000300, 32'h00000200);
        wait_done(lat, bok);
        chk("b2b_first_latency", 32'(lat), 32'd41);
        chk("b2b_first_val", val, 32'h00000180);
        launch(1'b0, 32'hFFFFFD00, 32'h00000200);
        wait_done(lat, bok);
        chk("b2b_second_latency", 32'(lat), 32'd41);
        chk("b2b_second_val", val, 32'hFFFFFE80);
        @(negedge clk);
        chk("b2b_done_pulse", {31'd0, done}, 32'd0);

        // Reset in the middle of a divide.
        launch(1'b0, 32'h00000300, 32'h00000200);
        repeat (9) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_val", val, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        chk("midrst_no_done", 32'(pulses), 32'd0);
        run_check("after_rst", 1'b0, 32'h00000300, 32'h00000200, 32'h00000180, 1'b0);

        // Random operations against the model.
        for (int i = 0; i < 150; i++) begin
            o = 1'($urandom_range(0, 1));
            x = $urandom;
            x = 32'($signed(x) >>> $urandom_range(0, 31));
            y = $urandom;
            y = 32'($signed(y) >>> $urandom_range(0, 31));
            if ($urandom_range(0, 15) == 0) y = 32'd0;
            model(o, x, y, ev, ee);
            run_check($sformatf("rnd%0d", i), o, x, y, ev, ee);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
